// File: rtl/uart_tx_controlpath.sv
// uart_tx_controlpath: UART transmit frame sequencer (start, 8 data bits, optional parity, stop).
// Define UART_TX_PARITY_EN to insert the parity bit time and drive par_load.
module uart_tx_controlpath (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       tx_req,
  input  logic       tx_abort,
  output logic       data_load,
  output logic       par_load,
  output logic       data_shift,
  output logic [1:0] line_sel,
  output logic       tx_busy,
  output logic       tx_done
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  state_t     state, state_n;
  logic [3:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic       load_n, shift_n, done_n, bit_end;
  logic [1:0] line_n;
  assign bit_end = baud_tick && (tick_cnt == 4'd15);
`ifdef UART_TX_PARITY_EN
  assign par_load = data_load;
`else
  assign par_load = 1'b0;
`endif
  always_comb begin
    state_n = state;
    tick_n  = (state != IDLE && baud_tick) ? tick_cnt + 4'd1 : tick_cnt;
    bit_n   = bit_cnt;
    load_n  = 1'b0;
    shift_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        tick_n = 4'd0;
        if (tx_req && !tx_abort) begin
          state_n = START;
          load_n  = 1'b1;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n   = 3'd0;
      end
      DATA: if (bit_end) begin
        shift_n = 1'b1;
        bit_n   = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_cnt == 3'd7) state_n = PARITY;
`else
        if (bit_cnt == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: if (bit_end) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
        tick_n  = 4'd0;
        bit_n   = 3'd0;
      end
    endcase
    // abort outranks any bit-end transition computed above
    if (tx_abort && state != IDLE) begin
      state_n = IDLE;
      tick_n  = 4'd0;
      bit_n   = 3'd0;
      shift_n = 1'b0;
      done_n  = 1'b0;
    end
    line_n = state_n == START  ? 2'b00 :
             state_n == DATA   ? 2'b01 :
             state_n == PARITY ? 2'b10 : 2'b11;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      data_load  <= 1'b0;
      data_shift <= 1'b0;
      tx_done    <= 1'b0;
      tx_busy    <= 1'b0;
      line_sel   <= 2'b11;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      data_load  <= load_n;
      data_shift <= shift_n;
      tx_done    <= done_n;
      tx_busy    <= state_n != IDLE;
      line_sel   <= line_n;
    end
  end
endmodule

// File: doc/uart_tx_controlpath.md
UART_TX_CONTROLPATH -- requirements
Module: uart_tx_controlpath

Interface
REQ-001 SHALL: clock  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: baud_tick  input  1  16x-oversample enable, one clock wide.
REQ-004 SHALL: tx_req  input  1  level request to send the byte held in the Tx datapath.
REQ-005 SHALL: tx_abort  input  1  synchronous abort of the frame in progress.
REQ-006 SHALL: data_load  output  1  one-clock pulse that loads the datapath PISO.
REQ-007 SHALL: par_load  output  1  one-clock pulse that loads the parity generator; coincident with data_load.
REQ-008 SHALL: data_shift  output  1  one-clock pulse that shifts the PISO by one bit.
REQ-009 SHALL: line_sel  output  2  Tx line mux select: 00 start (0), 01 PISO LSB, 10 parity bit, 11 mark (1).
REQ-010 SHALL: tx_busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL: tx_done  output  1  one-clock pulse on normal frame completion.

Function
REQ-012 SHALL: implement states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 SHALL: keep a 4-bit tick_cnt and a 3-bit bit_cnt; "bit end" = baud_tick high with tick_cnt==15.
REQ-014 SHALL: in IDLE, tick_cnt is held at 0 and line_sel=11.
REQ-015 SHALL: in IDLE, tx_req=1 at an edge moves the block to START on that edge, with data_load=par_load=1 for exactly that next cycle.
REQ-016 SHALL: in any non-IDLE state, tick_cnt increments on each baud_tick and wraps 15->0 at bit end; tick_cnt holds when baud_tick=0.
REQ-017 SHALL: in START, line_sel=00; at bit end, move to DATA with bit_cnt=0.
REQ-018 SHALL: in DATA, line_sel=01; at each bit end, assert data_shift for one cycle.
REQ-019 SHALL: in DATA, bit_cnt increments at each bit end; at bit end with bit_cnt==7, move to PARITY (macro defined) or STOP (macro undefined).
REQ-020 SHALL: in PARITY, line_sel=10; at bit end, move to STOP.
REQ-021 SHALL: in STOP, line_sel=11; at bit end, move to IDLE with tx_done=1 for that next cycle.
REQ-022 SHALL: ignore tx_req while tx_busy=1; no queuing.
REQ-023 SHALL: when tx_req is held high through completion, accept the new frame on the first edge in IDLE, giving a minimum one-clock IDLE gap between frames.
REQ-024 SHALL: on tx_abort=1 in any non-IDLE state, at the next edge go to IDLE with tick_cnt=0 and bit_cnt=0, no tx_done, and no data_shift.
REQ-025 SHALL: tx_abort has priority over bit-end transitions; tx_abort in IDLE has no effect and blocks acceptance of tx_req that cycle.
REQ-026 SHALL: treat an illegal state encoding as IDLE on the next edge.

Reset
REQ-027 SHALL: reset_n=0 immediately forces state IDLE, tick_cnt=0, bit_cnt=0, data_load=0, par_load=0, data_shift=0, tx_done=0, tx_busy=0, line_sel=11.
REQ-028 SHALL: reset mid-frame abandons the frame without a tx_done pulse; the line returns to mark immediately.
REQ-029 SHALL: after reset_n deasserts, accept tx_req on the first rising edge.

Configuration
REQ-030 SHALL: macro UART_TX_PARITY_EN defined: PARITY state present; frame = 11 bit times = 176 baud_ticks; par_load is driven as in REQ-015.
REQ-031 SHALL: macro UART_TX_PARITY_EN undefined: PARITY state and line_sel=10 never occur; DATA goes directly to STOP; frame = 160 baud_ticks; par_load is tied to 0.

Verification
REQ-032 SHALL: baud_tick every 4 clocks, one tx_req pulse, parity enabled -> one data_load/par_load pulse; 8 data_shift pulses spaced 64 clocks apart; line_sel sequence 00,01,10,11; tx_done 704 clocks after START entry.
REQ-033 SHALL: same stimulus with UART_TX_PARITY_EN undefined -> line_sel never 10; tx_done 640 clocks after START entry; par_load always 0.
REQ-034 SHALL: tx_req held high for 3 frames -> exactly 3 data_load pulses; each new START one clock after the tx_done cycle; tx_req ignored while busy.
REQ-035 SHALL: tx_abort asserted at bit_cnt=3 in DATA -> IDLE next edge; line_sel=11; no tx_done; no further data_shift; next tx_req accepted normally.
REQ-036 SHALL: reset_n pulled low mid-PARITY -> all outputs at reset values asynchronously; first edge after release with tx_req=1 -> START.
REQ-037 SHALL: baud_tick held low for 100 clocks inside START -> tick_cnt frozen; no state change; no output pulses.
